// File: rtl/flopoco_to_ieee_pipe.sv
// Two-stage valid/ready converter from FloPoCo floating-point words to IEEE-754 words of equal WE/WF.
// Define FLOPOCO_TO_IEEE_STICKY_EN to build the sticky {nan, inf, zero, subnormal} flags.
module flopoco_to_ieee_pipe #(
  parameter int unsigned WE = 8,
  parameter int unsigned WF = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WE+WF+2:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WE+WF:0]    out_data,
  input  logic              flag_clr,
  output logic [3:0]        flags
);

  localparam int unsigned IW = WE + WF + 3;
  localparam int unsigned OW = WE + WF + 1;

  typedef enum logic [2:0] {CLS_ZERO, CLS_SUB, CLS_NORM, CLS_INF, CLS_NAN} cls_e;

  logic          v1_q, v1_d, v2_q, v2_d;
  logic [OW-1:0] d1_q, d1_d, d2_q, d2_d;
  cls_e          cls1_q, cls1_d, cls2_q, cls2_d;
  cls_e          cls_in;
  logic [OW-1:0] asm_c;
  logic          adv1, adv2;

  assign adv2      = !v2_q || out_ready;
  assign adv1      = !v1_q || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2_q;
  assign out_data  = d2_q;

  // Classify the incoming word from its exception field and exponent.
  always_comb begin
    cls_in = CLS_NORM;
    case (in_data[IW-1 -: 2])
      2'b00:   cls_in = CLS_ZERO;
      2'b01:   cls_in = (in_data[WE+WF-1:WF] == '0) ? CLS_SUB : CLS_NORM;
      2'b10:   cls_in = CLS_INF;
      default: cls_in = CLS_NAN;
    endcase
  end

  // Build the IEEE word for the stage-1 entry; subnormals drop the input LSB.
  always_comb begin
    asm_c = d1_q;
    case (cls1_q)
      CLS_ZERO: asm_c = {d1_q[OW-1], WE'(0), WF'(0)};
      CLS_SUB:  asm_c = {d1_q[OW-1], WE'(0), 1'b1, d1_q[WF-1:1]};
      CLS_INF:  asm_c = {d1_q[OW-1], {WE{1'b1}}, WF'(0)};
      CLS_NAN:  asm_c = {1'b0, {WE{1'b1}}, WF'(1)};
      default:  asm_c = d1_q;
    endcase
  end

  always_comb begin
    v1_d   = v1_q;
    d1_d   = d1_q;
    cls1_d = cls1_q;
    v2_d   = v2_q;
    d2_d   = d2_q;
    cls2_d = cls2_q;
    if (adv1) v1_d = in_valid;
    if (adv1 && in_valid) begin
      d1_d   = in_data[OW-1:0];
      cls1_d = cls_in;
    end
    if (adv2) v2_d = v1_q;
    if (adv2 && v1_q) begin
      d2_d   = asm_c;
      cls2_d = cls1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      d1_q   <= '0;
      cls1_q <= CLS_ZERO;
      v2_q   <= 1'b0;
      d2_q   <= '0;
      cls2_q <= CLS_ZERO;
    end else begin
      v1_q   <= v1_d;
      d1_q   <= d1_d;
      cls1_q <= cls1_d;
      v2_q   <= v2_d;
      d2_q   <= d2_d;
      cls2_q <= cls2_d;
    end
  end

`ifdef FLOPOCO_TO_IEEE_STICKY_EN
  logic [3:0] flags_q, flags_d, flag_set;

  // A word leaving stage 2 sets its class bit; setting beats a coincident clear.
  always_comb begin
    flag_set = '0;
    if (v2_q && out_ready) begin
      case (cls2_q)
        CLS_NAN:  flag_set[3] = 1'b1;
        CLS_INF:  flag_set[2] = 1'b1;
        CLS_ZERO: flag_set[1] = 1'b1;
        CLS_SUB:  flag_set[0] = 1'b1;
        default:  flag_set    = '0;
      endcase
    end
    flags_d = (flags_q & ~{4{flag_clr}}) | flag_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;
`else
  logic unused_c;
  assign unused_c = flag_clr | (|cls2_q);
  assign flags    = '0;
`endif

endmodule

// File: tb/tb_flopoco_to_ieee_pipe.sv
// Directed bench for flopoco_to_ieee_pipe: conversions, latency, backpressure, reset, widths, flags.
module tb_flopoco_to_ieee_pipe;

`ifdef FLOPOCO_TO_IEEE_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1, flag_clr = 1'b0;
  logic [33:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [3:0]  flags;

  logic [65:0] dbl_in = {2'b11, 64'h0123_4567_89AB_CDEF};
  logic        dbl_ir, dbl_ov;
  logic [63:0] dbl_out;
  logic [3:0]  dbl_flags;
  logic [17:0] half_in = {2'b11, 16'h9234};
  logic        half_ir, half_ov;
  logic [15:0] half_out;
  logic [3:0]  half_flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flopoco_to_ieee_pipe #(.WE(8), .WF(23)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flag_clr(flag_clr), .flags(flags)
  );

  flopoco_to_ieee_pipe #(.WE(11), .WF(52)) u_dbl (
    .clk(clk), .rst_n(rst_n), .in_valid(1'b1), .in_ready(dbl_ir), .in_data(dbl_in),
    .out_valid(dbl_ov), .out_ready(1'b1), .out_data(dbl_out),
    .flag_clr(1'b0), .flags(dbl_flags)
  );

  flopoco_to_ieee_pipe #(.WE(5), .WF(10)) u_half (
    .clk(clk), .rst_n(rst_n), .in_valid(1'b1), .in_ready(half_ir), .in_data(half_in),
    .out_valid(half_ov), .out_ready(1'b1), .out_data(half_out),
    .flag_clr(1'b0), .flags(half_flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_checks++; if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", flags); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Sends one word, checks the two-cycle latency and the converted value.
  task automatic send_check(input string name, input logic [33:0] din, input logic [31:0] exp);
    in_valid = 1'b1;
    in_data  = din;
    tick();
    in_valid = 1'b0;
    in_data  = 34'h3_FFFF_FFFF;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early_valid got %b want 0", name, out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid got %b want 1", name, out_valid); end
    n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL %s_data got %h want %h", name, out_data, exp); end
  endtask

  task automatic test_normal();
    send_check("normal", 34'h1_3F80_0000, 32'h3F80_0000);
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL normal_drain got %b want 0", out_valid); end
  endtask

  task automatic test_subnormal_flags();
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    send_check("subnormal", 34'h1_8040_0000, 32'h8060_0000);
    tick();
    n_checks++; if (flags !== (STICKY ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL sub_flags got %b want %b", flags, STICKY ? 4'b0001 : 4'b0000); end
    // A zero leaves in the same cycle as a clear: the zero bit must survive.
    send_check("zero_clr", 34'h0_0000_0000, 32'h0000_0000);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    n_checks++; if (flags !== (STICKY ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL clr_vs_set_flags got %b want %b", flags, STICKY ? 4'b0010 : 4'b0000); end
  endtask

  task automatic test_specials();
    logic [33:0] din [3] = '{34'h0_8000_0000, 34'h2_8000_0000, 34'h3_8123_4567};
    logic [31:0] exp [3] = '{32'h8000_0000, 32'hFF80_0000, 32'h7F80_0001};
    for (int i = 0; i < 3; i++) begin
      send_check($sformatf("special%0d", i), din[i], exp[i]);
      tick();
    end
    n_checks++; if (flags !== (STICKY ? 4'b1110 : 4'b0000)) begin n_fail++; $display("FAIL special_flags got %b want %b", flags, STICKY ? 4'b1110 : 4'b0000); end
  endtask

  // Streams 8 words with out_ready low in cycles 3..6 of the stream.
  task automatic test_backpressure();
    logic [31:0] words [8];
    logic [31:0] held;
    logic        was_stalled;
    int sent, recv;
    for (int i = 0; i < 8; i++) words[i] = 32'h4000_0000 + 32'(i * 32'h111);
    sent = 0; recv = 0; was_stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      in_valid  = (sent < 8);
      in_data   = {2'b01, words[sent < 8 ? sent : 7]};
      out_ready = !(cyc >= 3 && cyc <= 6);
      #1;
      if (cyc < 10) begin
        n_checks++;
        if (in_ready !== !(cyc >= 3 && cyc <= 6)) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b want %b", cyc, in_ready, !(cyc >= 3 && cyc <= 6)); end
      end
      if (was_stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin n_fail++; $display("FAIL bp_stall_hold cyc %0d got %b/%h want 1/%h", cyc, out_valid, out_data, held); end
      end
      was_stalled = out_valid && !out_ready;
      held        = out_data;
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_data !== words[recv]) begin n_fail++; $display("FAIL bp_order word %0d got %h want %h", recv, out_data, words[recv]); end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (recv !== 8) begin n_fail++; $display("FAIL bp_count got %0d want 8", recv); end
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_extra_word got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    logic seen;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 34'h1_3F80_0000;
    tick();
    in_data   = 34'h1_4000_0000;
    tick();
    in_valid  = 1'b0;
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_full got ready %b valid %b want 0 1", in_ready, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin n_fail++; $display("FAIL mid_reset_out got %b/%h want 0/0", out_valid, out_data); end
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready got %b want 1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | out_valid;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_stale_word got %b want 0", seen); end
  endtask

  task automatic test_widths();
    tick();
    tick();
    tick();
    n_checks++; if (dbl_ov !== 1'b1) begin n_fail++; $display("FAIL dbl_valid got %b want 1", dbl_ov); end
    n_checks++; if (dbl_out !== 64'h7FF0_0000_0000_0001) begin n_fail++; $display("FAIL dbl_nan got %h want 7ff0000000000001", dbl_out); end
    n_checks++; if (half_ov !== 1'b1) begin n_fail++; $display("FAIL half_valid got %b want 1", half_ov); end
    n_checks++; if (half_out !== 16'h7C01) begin n_fail++; $display("FAIL half_nan got %h want 7c01", half_out); end
    n_checks++; if (dbl_flags !== (STICKY ? 4'b1000 : 4'b0000)) begin n_fail++; $display("FAIL dbl_flags got %b want %b", dbl_flags, STICKY ? 4'b1000 : 4'b0000); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_subnormal_flags();
    test_specials();
    test_backpressure();
    test_reset_midstream();
    test_widths();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
